// File: rtl/riscv_pkg.sv
// Shared constants and types for the integer pipeline: ALU operation codes,
// datapath widths and the forwarding-source selector.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALU_CTRL_W = 4;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd6,
    ALU_SLT = 4'd7,
    ALU_NOR = 4'd12
  } alu_op_e;

  // Source of an EX operand: the value registered at decode, or a bypass.
  typedef enum logic [1:0] {
    FWD_REG,
    FWD_MEMWB,
    FWD_EXMEM
  } fwd_sel_t;

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Operand bypass selector for one EX source register: decides whether a newer
// result from EX/MEM or MEM/WB overrides the value captured at decode.
module fwd_unit
  import riscv_pkg::*;
#(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  exmem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]       exmem_alu_out_i,
  input  logic                  memwb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]       memwb_wdata_i,
  output fwd_sel_t              sel_o,
  output logic [XLEN-1:0]       data_o
);

  logic exmem_hit;
  logic memwb_hit;

  // x0 is hard-wired zero, so a write targeting it must never be bypassed.
  assign exmem_hit = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_i);
  assign memwb_hit = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_i);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_o  = FWD_REG;
    data_o = memwb_wdata_i;
    if (exmem_hit) begin
      sel_o  = FWD_EXMEM;
      data_o = exmem_alu_out_i;
    end else if (memwb_hit) begin
      sel_o  = FWD_MEMWB;
      data_o = memwb_wdata_i;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, capture-time
// write-back bypass and EX-side operand forwarding feeding the ALU directly.
module id_ex_stage #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int ALU_CTRL_W = riscv_pkg::ALU_CTRL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [ALU_CTRL_W-1:0] id_alu_control,
  input  logic                  id_alu_src,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_branch,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_alu_out,
  input  logic                  memwb_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_wdata,
  output logic                  load_use_stall,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_alu_a,
  output logic [XLEN-1:0]       ex_alu_b,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_branch
);

  import riscv_pkg::*;

  logic                  valid_q,      valid_d;
  logic [XLEN-1:0]       pc_q,         pc_d;
  logic [XLEN-1:0]       imm_q,        imm_d;
  logic [XLEN-1:0]       rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q,   rs2_data_d;
  logic [REG_ADDR_W-1:0] rs1_q,        rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,        rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,         rd_d;
  logic [ALU_CTRL_W-1:0] alu_control_q, alu_control_d;
  logic                  alu_src_q,    alu_src_d;
  logic                  reg_write_q,  reg_write_d;
  logic                  mem_read_q,   mem_read_d;
  logic                  mem_write_q,  mem_write_d;
  logic                  mem_to_reg_q, mem_to_reg_d;
  logic                  branch_q,     branch_d;

  logic            wb_byp_rs1;
  logic            wb_byp_rs2;
  fwd_sel_t        fwd_a_sel;
  fwd_sel_t        fwd_b_sel;
  logic [XLEN-1:0] fwd_a_data;
  logic [XLEN-1:0] fwd_b_data;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  // A load in EX cannot supply its data until MEM, so a dependent instruction
  // in ID must wait one cycle behind a bubble.
  assign load_use_stall = valid_q && mem_read_q && (rd_q != '0) &&
                          ((rd_q == id_rs1) || (rd_q == id_rs2)) &&
                          id_valid && !flush_in;

  // The register file is read before the MEM/WB write lands; take it directly.
  assign wb_byp_rs1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs1);
  assign wb_byp_rs2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == id_rs2);

  always_comb begin
    valid_d       = valid_q;
    pc_d          = pc_q;
    imm_d         = imm_q;
    rs1_data_d    = rs1_data_q;
    rs2_data_d    = rs2_data_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    rd_d          = rd_q;
    alu_control_d = alu_control_q;
    alu_src_d     = alu_src_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    branch_d      = branch_q;

    if (stall_in) begin
      // Hold everything; a concurrent flush is re-presented by its source.
    end else if (flush_in || load_use_stall) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      branch_d     = 1'b0;
    end else begin
      valid_d       = id_valid;
      pc_d          = id_pc;
      imm_d         = id_imm;
      rs1_data_d    = wb_byp_rs1 ? memwb_wdata : id_rs1_data;
      rs2_data_d    = wb_byp_rs2 ? memwb_wdata : id_rs2_data;
      rs1_d         = id_rs1;
      rs2_d         = id_rs2;
      rd_d          = id_rd;
      alu_control_d = id_alu_control;
      alu_src_d     = id_alu_src;
      reg_write_d   = id_reg_write  && id_valid;
      mem_read_d    = id_mem_read   && id_valid;
      mem_write_d   = id_mem_write  && id_valid;
      mem_to_reg_d  = id_mem_to_reg && id_valid;
      branch_d      = id_branch     && id_valid;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_control_q <= '0;
      alu_src_q     <= 1'b0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      branch_q      <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      pc_q          <= pc_d;
      imm_q         <= imm_d;
      rs1_data_q    <= rs1_data_d;
      rs2_data_q    <= rs2_data_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      rd_q          <= rd_d;
      alu_control_q <= alu_control_d;
      alu_src_q     <= alu_src_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      branch_q      <= branch_d;
    end
  end

  fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_i              (rs1_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_alu_out_i   (exmem_alu_out),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_wdata_i     (memwb_wdata),
    .sel_o             (fwd_a_sel),
    .data_o            (fwd_a_data)
  );

  fwd_unit #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_i              (rs2_q),
    .exmem_reg_write_i (exmem_reg_write),
    .exmem_rd_i        (exmem_rd),
    .exmem_alu_out_i   (exmem_alu_out),
    .memwb_reg_write_i (memwb_reg_write),
    .memwb_rd_i        (memwb_rd),
    .memwb_wdata_i     (memwb_wdata),
    .sel_o             (fwd_b_sel),
    .data_o            (fwd_b_data)
  );

  assign rs1_fwd = (fwd_a_sel == FWD_REG) ? rs1_data_q : fwd_a_data;
  assign rs2_fwd = (fwd_b_sel == FWD_REG) ? rs2_data_q : fwd_b_data;

  assign ex_valid       = valid_q;
  assign ex_pc          = pc_q;
  assign ex_imm         = imm_q;
  assign ex_alu_a       = rs1_fwd;
  assign ex_alu_b       = alu_src_q ? imm_q : rs2_fwd;
  assign ex_store_data  = rs2_fwd;
  assign ex_alu_control = alu_control_q;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_read    = mem_read_q;
  assign ex_mem_write   = mem_write_q;
  assign ex_mem_to_reg  = mem_to_reg_q;
  assign ex_branch      = branch_q;

endmodule
